// File: rtl/sev_seg_reader_if.sv
// Display-bus and frame-handshake bundle for the 7-segment readback block.
// The slave side belongs to sev_seg_reader; the master side drives the panel and consumes frames.
interface sev_seg_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   an_in;
    logic [4*DIGITS-1:0] out_digits;
    logic [DIGITS-1:0]   out_err;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport master (
        output seg_in, an_in, out_ready,
        input  out_digits, out_err, out_valid, busy
    );

    modport slave (
        input  seg_in, an_in, out_ready,
        output out_digits, out_err, out_valid, busy
    );
endinterface

// File: rtl/sev_seg_reader.sv
// Reads a multiplexed active-low 7-segment display back into hex nibbles and
// hands out one frame per complete scan through a valid/ready handshake.
module sev_seg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    sev_seg_reader_if.slave  bus
);
    localparam int              CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [6:0]          seg_m_q, seg_m_d, seg_s_q, seg_s_d;
    logic [DIGITS-1:0]   an_m_q, an_m_d, an_s_q, an_s_d;
    logic [DIGITS+6:0]   prev_q, prev_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                captured_q, captured_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] work_digit_q, work_digit_d;
    logic [DIGITS-1:0]   work_err_q, work_err_d;
    logic [4*DIGITS-1:0] out_digits_q, out_digits_d;
    logic [DIGITS-1:0]   out_err_q, out_err_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [DIGITS+6:0]   cur;
    logic                changed;
    logic                capture;
    logic                load;
    logic [DIGITS-1:0]   cap_mask;

    // {err, value}; anything that is not one of the sixteen glyphs flags err with value 0
    function automatic logic [4:0] encode(input logic [6:0] seg);
        case (seg)
            7'b1000000: encode = 5'h00;
            7'b1111001: encode = 5'h01;
            7'b0100100: encode = 5'h02;
            7'b0110000: encode = 5'h03;
            7'b0011001: encode = 5'h04;
            7'b0010010: encode = 5'h05;
            7'b0000010: encode = 5'h06;
            7'b1111000: encode = 5'h07;
            7'b0000000: encode = 5'h08;
            7'b0010000: encode = 5'h09;
            7'b0001000: encode = 5'h0A;
            7'b0000011: encode = 5'h0B;
            7'b1000110: encode = 5'h0C;
            7'b0100001: encode = 5'h0D;
            7'b0000110: encode = 5'h0E;
            7'b0001110: encode = 5'h0F;
            default:    encode = 5'h10;
        endcase
    endfunction

    function automatic logic one_cold(input logic [DIGITS-1:0] an);
        int zeros;
        zeros = 0;
        for (int i = 0; i < DIGITS; i++) begin
            zeros += an[i] ? 0 : 1;
        end
        return zeros == 1;
    endfunction

    always_comb begin
        seg_m_d = bus.seg_in;
        seg_s_d = seg_m_q;
        an_m_d  = bus.an_in;
        an_s_d  = an_m_q;

        cur     = {an_s_q, seg_s_q};
        prev_d  = cur;
        changed = (cur != prev_q);

        if (changed) begin
            cnt_d      = '0;
            captured_d = 1'b0;
        end else begin
            cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            captured_d = captured_q;
        end

        // cnt_d reaching CNT_MAX means the current sample is the STABLE_CYCLES-th identical one
        capture      = (cnt_d == CNT_MAX) && !captured_d && one_cold(an_s_q);
        cap_mask     = '0;
        work_digit_d = work_digit_q;
        work_err_d   = work_err_q;
        if (capture) begin
            captured_d = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (!an_s_q[i]) begin
                    {work_err_d[i], work_digit_d[4*i +: 4]} = encode(seg_s_q);
                    cap_mask[i] = 1'b1;
                end
            end
        end

        // A capture landing with the load goes out in this frame and does not re-arm seen
        load         = (&seen_q) && (!out_valid_q || bus.out_ready);
        out_digits_d = out_digits_q;
        out_err_d    = out_err_q;
        out_valid_d  = out_valid_q;
        seen_d       = seen_q | cap_mask;
        if (load) begin
            out_digits_d = work_digit_d;
            out_err_d    = work_err_d;
            out_valid_d  = 1'b1;
            seen_d       = '0;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
        busy_d = |seen_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m_q      <= '0;
            seg_s_q      <= '0;
            an_m_q       <= '0;
            an_s_q       <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            captured_q   <= 1'b0;
            seen_q       <= '0;
            work_digit_q <= '0;
            work_err_q   <= '0;
            out_digits_q <= '0;
            out_err_q    <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            seg_m_q      <= seg_m_d;
            seg_s_q      <= seg_s_d;
            an_m_q       <= an_m_d;
            an_s_q       <= an_s_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            captured_q   <= captured_d;
            seen_q       <= seen_d;
            work_digit_q <= work_digit_d;
            work_err_q   <= work_err_d;
            out_digits_q <= out_digits_d;
            out_err_q    <= out_err_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.out_digits = out_digits_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
endmodule
